fp_pack_norm: RTL and testbench

Result normalizer and packer for the floating-point ALU: the inverse of the operand field splitter. It accepts an unnormalized sign/exponent/mantissa result from the arithmetic stages, then normalizes it iteratively, one bit per cycle. It rounds to nearest-even and packs the value into an IEEE-754 single-precision word with overflow, underflow and inexact flags. Input and output use valid/ready handshakes; one operation is in flight at a time.

---
 rtl/fp_pkg.sv | 13 +
 rtl/fp_pack_norm_if.sv | 32 +++
 rtl/fp_round_rne.sv | 36 +++
 rtl/fp_pack_norm.sv | 108 ++++++++++
 tb/tb_fp_pack_norm.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared constants and types for the floating-point result packer
// Holds IEEE-754 single-precision field widths, bias, special encodings and the
// normalizer state enum. Ports: none (package).
package fp_pkg;
    localparam int FP_BIAS       = 127;
    localparam int EXP_FIELD_MAX = 255;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam int SIGN_W = 1;
    localparam int EXPF_W = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = 28;
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
endpackage

// File: rtl/fp_pack_norm_if.sv
// fp_pack_norm_if: request/result bundle between the arithmetic stages and the packer
// Request side: in_valid/in_ready handshake carrying in_sign, in_exp (signed biased,
// weight of mantissa bit 26), in_mant (carry, hidden, fraction, guard, round, sticky),
// in_nan and in_inf. Result side: out_valid/out_ready handshake carrying result and
// the overflow/underflow/inexact flags. slave = packer, master = producer/consumer.
interface fp_pack_norm_if #(
    parameter int EXP_W = 10
);
    logic                            in_valid;
    logic                            in_ready;
    logic                            in_sign;
    logic signed [EXP_W-1:0]         in_exp;
    logic [fp_pkg::MANT_W-1:0]       in_mant;
    logic                            in_nan;
    logic                            in_inf;
    logic                            out_valid;
    logic                            out_ready;
    logic [31:0]                     result;
    logic                            overflow;
    logic                            underflow;
    logic                            inexact;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, inexact
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, out_ready,
        output in_ready, out_valid, result, overflow, underflow, inexact
    );
endinterface

// File: rtl/fp_round_rne.sv
// fp_round_rne: combinational round-to-nearest-even and single-precision packing
// Ports: sign, exp_in (signed biased exponent), mant (hidden, fraction, g, r, s)
// in; packed result plus overflow, underflow and inexact flags out.
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int EXP_W = 10
) (
    input  logic                    sign,
    input  logic signed [EXP_W-1:0] exp_in,
    input  logic [26:0]             mant,
    output logic [31:0]             result,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    inexact
);
    localparam logic signed [EXP_W-1:0] FIELD_MAX = EXP_W'(EXP_FIELD_MAX);

    logic                    inc;
    logic [24:0]             sum;
    logic signed [EXP_W-1:0] exp_r;
    logic [EXPF_W-1:0]       field;

    always_comb begin
        inc       = mant[2] & (mant[1] | mant[0] | mant[3]);
        sum       = {1'b0, mant[26:3]} + {24'h0, inc};
        exp_r     = sum[24] ? exp_in + EXP_W'(1) : exp_in;
        overflow  = exp_r >= FIELD_MAX;
        // a hidden bit of 0 after rounding can only happen at exp 1: denormal or zero
        field     = (sum[24] | sum[23]) ? exp_r[EXPF_W-1:0] : '0;
        inexact   = overflow | (|mant[2:0]);
        // tininess is judged before rounding, from the pre-rounding hidden bit
        underflow = inexact & ~mant[26];
        result    = overflow ? {sign, 8'hFF, 23'h0} : {sign, field, sum[FRAC_W-1:0]};
    end
endmodule

// File: rtl/fp_pack_norm.sv
// fp_pack_norm: iterative result normalizer and IEEE-754 single-precision packer
// Ports: clk, reset (asynchronous, active-low), bus (fp_pack_norm_if.slave) with the
// request handshake in and the packed result plus status flags out. One operation
// in flight; normalization shifts one bit per cycle, then a rounding cycle.
module fp_pack_norm
    import fp_pkg::*;
#(
    parameter int EXP_W = 10
) (
    input logic           clk,
    input logic           reset,
    fp_pack_norm_if.slave bus
);
    localparam logic signed [EXP_W-1:0] E_ONE  = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] E_TINY = EXP_W'(-25);

    state_t                  state, state_n;
    logic                    sign_q, sign_d;
    logic signed [EXP_W-1:0] exp_q, exp_d;
    logic [MANT_W-1:0]       mant_q, mant_d, mant_sr;
    logic [31:0]             result_q, result_d, rnd_result;
    logic [2:0]              flags_q, flags_d, rnd_flags;

    fp_round_rne #(.EXP_W(EXP_W)) u_round (
        .sign      (sign_q),
        .exp_in    (exp_q),
        .mant      (mant_q[26:0]),
        .result    (rnd_result),
        .overflow  (rnd_flags[2]),
        .underflow (rnd_flags[1]),
        .inexact   (rnd_flags[0])
    );

    // right shift that folds the dropped bit into the sticky position
    assign mant_sr = {1'b0, mant_q[MANT_W-1:2], |mant_q[1:0]};

    always_comb begin
        state_n  = state;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state)
            IDLE: if (bus.in_valid) begin
                sign_d = bus.in_sign;
                exp_d  = bus.in_exp;
                mant_d = bus.in_mant;
                if (bus.in_nan || bus.in_inf || bus.in_mant == '0) begin
                    state_n  = DONE;
                    flags_d  = '0;
                    result_d = bus.in_nan ? QNAN :
                               bus.in_inf ? {bus.in_sign, 8'hFF, 23'h0} : {bus.in_sign, 31'h0};
                end else begin
                    state_n = NORM;
                end
            end
            NORM: if (mant_q[MANT_W-1]) begin
                mant_d  = mant_sr;
                exp_d   = exp_q + E_ONE;
                state_n = ROUND;
            end else if (exp_q < E_TINY) begin
                // too small to reach the guard bit even at the lowest exponent
                mant_d = {27'h0, |mant_q};
                exp_d  = E_ONE;
            end else if (exp_q < E_ONE) begin
                mant_d = mant_sr;
                exp_d  = exp_q + E_ONE;
            end else if (!mant_q[26] && exp_q > E_ONE) begin
                mant_d = {mant_q[MANT_W-2:0], 1'b0};
                exp_d  = exp_q - E_ONE;
            end else begin
                state_n = ROUND;
            end
            ROUND: begin
                result_d = rnd_result;
                flags_d  = rnd_flags;
                state_n  = DONE;
            end
            DONE: if (bus.out_ready) state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state    <= state_n;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.result    = result_q;
    assign bus.overflow  = flags_q[2];
    assign bus.underflow = flags_q[1];
    assign bus.inexact   = flags_q[0];
endmodule

// File: tb/tb_fp_pack_norm.sv
// tb_fp_pack_norm: directed and randomized checks of fp_pack_norm against a value-level model
module tb_fp_pack_norm;
    import fp_pkg::*;

    localparam int EXP_W = 10;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fp_pack_norm_if #(.EXP_W(EXP_W)) bus ();
    fp_pack_norm #(.EXP_W(EXP_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Rounds the exact value m * 2^(e-153) to single precision, nearest-even.
    function automatic void model(input logic s, input int e, input logic [27:0] m,
                                  input logic nan, input logic inf,
                                  output logic [31:0] r, output logic [2:0] fl);
        int p, ev, q, sh, be;
        longint unsigned mm, kept, rem, half;
        logic ov, un, ix, tiny;
        r  = '0;
        fl = '0;
        if (nan) r = QNAN;
        else if (inf) r = {s, 8'hFF, 23'h0};
        else if (m == 0) r = {s, 31'h0};
        else begin
            p = 0;
            for (int i = 0; i < 28; i++) if (m[i]) p = i;
            ev   = p + e - 153;
            tiny = ev < -126;
            q    = (tiny ? -126 : ev) - 23;
            sh   = q - (e - 153);
            mm   = 64'(m);
            ix   = 1'b0;
            if (sh <= 0) kept = mm << (-sh);
            else if (sh > 40) begin
                kept = 0;
                ix   = 1'b1;
            end else begin
                kept = mm >> sh;
                rem  = mm & ((64'd1 << sh) - 64'd1);
                half = 64'd1 << (sh - 1);
                ix   = rem != 0;
                if (rem > half || (rem == half && kept[0])) kept++;
            end
            if (kept == (64'd1 << 24)) begin
                kept = 64'd1 << 23;
                q++;
            end
            be = (kept >= (64'd1 << 23)) ? q + 150 : 0;
            ov = be >= 255;
            un = ix & tiny;
            r  = ov ? {s, 8'hFF, 23'h0} : {s, 8'(be), kept[22:0]};
            fl = {ov, un, ix | ov};
        end
    endfunction

    task automatic issue(input logic s, input int e, input logic [27:0] m,
                         input logic nan, input logic inf);
        @(negedge clk);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = EXP_W'(e);
        bus.in_mant  = m;
        bus.in_nan   = nan;
        bus.in_inf   = inf;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_nan   = 1'b0;
        bus.in_inf   = 1'b0;
    endtask

    task automatic run(input logic s, input int e, input logic [27:0] m,
                       input logic nan, input logic inf,
                       output int lat, output logic [31:0] r, output logic [2:0] fl);
        issue(s, e, m, nan, inf);
        lat = 1;
        while (!bus.out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("out_valid_seen", 32'(bus.out_valid), 32'd1);
        r  = bus.result;
        fl = {bus.overflow, bus.underflow, bus.inexact};
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic dir(input string tag, input logic s, input int e, input logic [27:0] m,
                       input logic nan, input logic inf,
                       input logic [31:0] er, input logic [2:0] efl, input int elat);
        int lat;
        logic [31:0] r;
        logic [2:0] fl;
        run(s, e, m, nan, inf, lat, r, fl);
        chk({tag, "_result"}, r, er);
        chk({tag, "_flags"}, 32'(fl), 32'(efl));
        if (elat >= 0) chk({tag, "_latency"}, 32'(lat), 32'(elat));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, e;
        logic s, nan, inf;
        logic [27:0] m;
        logic [31:0] r, er;
        logic [2:0] fl, efl;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mant   = '0;
        bus.in_nan    = 1'b0;
        bus.in_inf    = 1'b0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_result", bus.result, 32'h0);
        chk("reset_flags", 32'({bus.overflow, bus.underflow, bus.inexact}), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        dir("normalized", 1'b0, 127, 28'h4000000, 1'b0, 1'b0, 32'h3F800000, 3'b000, 3);
        dir("left_norm",  1'b0, 150, 28'h0000008, 1'b0, 1'b0, 32'h3F800000, 3'b000, 26);
        dir("tie_even",   1'b0, 127, 28'h4000004, 1'b0, 1'b0, 32'h3F800000, 3'b001, -1);
        dir("tie_up",     1'b0, 127, 28'h400000C, 1'b0, 1'b0, 32'h3F800002, 3'b001, -1);
        dir("carry",      1'b0, 127, 28'h8000000, 1'b0, 1'b0, 32'h40000000, 3'b000, 3);
        dir("overflow",   1'b0, 254, 28'h7FFFFFC, 1'b0, 1'b0, 32'h7F800000, 3'b101, -1);
        dir("denorm",     1'b0, -22, 28'h4000000, 1'b0, 1'b0, 32'h00000001, 3'b000, -1);
        dir("denorm_ix",  1'b0, -22, 28'h4000001, 1'b0, 1'b0, 32'h00000001, 3'b011, -1);
        dir("nan",        1'b0, 0,   28'h4000000, 1'b1, 1'b0, 32'h7FC00000, 3'b000, 1);
        dir("neg_inf",    1'b1, 0,   28'h4000000, 1'b0, 1'b1, 32'hFF800000, 3'b000, 1);
        dir("neg_zero",   1'b1, 100, 28'h0000000, 1'b0, 1'b0, 32'h80000000, 3'b000, 1);

        issue(1'b0, 0, 28'h0, 1'b1, 1'b0);
        chk("bp_valid_c1", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_result", bus.result, QNAN);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("bp_released", 32'(bus.out_valid), 32'd0);

        dir("pre_reset", 1'b0, 127, 28'h4000004, 1'b0, 1'b0, 32'h3F800000, 3'b001, -1);
        issue(1'b0, 150, 28'h0000008, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        chk("rst_busy", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.result, 32'h0);
        chk("rst_flags", 32'({bus.overflow, bus.underflow, bus.inexact}), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        dir("post_reset", 1'b1, 128, 28'h6000000, 1'b0, 1'b0, 32'hC0400000, 3'b000, 3);

        for (int n = 0; n < 200; n++) begin
            s   = 1'($urandom());
            e   = int'($urandom_range(0, 330)) - 40;
            m   = 28'($urandom()) >> $urandom_range(0, 27);
            if (e < 0) m[27] = 1'b0;
            nan = $urandom_range(0, 15) == 0;
            inf = $urandom_range(0, 15) == 0;
            model(s, e, m, nan, inf, er, efl);
            run(s, e, m, nan, inf, lat, r, fl);
            chk("rand_result", r, er);
            chk("rand_flags", 32'(fl), 32'(efl));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
